// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the PISO serializer
// Contents: state_t (IDLE/SHIFT/PARITY), DEFAULT_WIDTH, cnt_width() counter sizing.
// Optional feature macro used by the design: PISO_PARITY_EN.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // The counter only needs to hold WIDTH-1, so $clog2(WIDTH) bits suffice.
    // The result is clamped to 1 so that the vector stays legal.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_if.sv
// rtl/piso_if.sv - load/serial-output bundle for the PISO serializer
// Signals: load_valid, din[WIDTH-1:0] (toward serializer);
//          load_ready, sout, sout_valid, done (from serializer).
// Modports: master = word source / bit sink, slave = serializer.
interface piso_if
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load_valid;
    logic [WIDTH-1:0] din;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load_valid, din,
        input  load_ready, sout, sout_valid, done
    );

    modport slave (
        input  load_valid, din,
        output load_ready, sout, sout_valid, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - loadable down-counter with zero flag
// Ports: clk, rst_n (async active-low), load, load_value[CW-1:0], dec, zero.
// load has priority over dec; the count does not wrap below zero.
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer, MSB first
// Ports: clk, rst_n (async active-low), bus (piso_if.slave: load_valid, din,
//        load_ready, sout, sout_valid, done).
// Macro PISO_PARITY_EN: append one even-parity bit (PARITY state) per frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    piso_if.slave   bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q;
    logic             done_q;
    logic             zero;
    logic             load;
    logic             final_bit;
    logic             ready;
    logic             sout_c;
    logic             valid_c;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    always_comb begin
        state_d   = state_q;
        final_bit = 1'b0;
        ready     = 1'b0;
        sout_c    = 1'b0;
        valid_c   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.load_valid) state_d = SHIFT;
            end
            SHIFT: begin
                sout_c  = sreg_q[WIDTH-1];
                valid_c = 1'b1;
                if (zero) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    // Last data bit: accept the next word on this edge.
                    final_bit = 1'b1;
                    ready     = 1'b1;
                    state_d   = bus.load_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout_c    = parity_q;
                valid_c   = 1'b1;
                final_bit = 1'b1;
                ready     = 1'b1;
                state_d   = bus.load_valid ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign load = ready && bus.load_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= final_bit;
            if (load) begin
                sreg_q <= bus.din;
            end else if (state_q == SHIFT) begin
                sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^bus.din;
        end
    end
`endif

    piso_bit_counter #(.CW(CW)) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (CW'(WIDTH - 1)),
        .dec        ((state_q == SHIFT) && !zero),
        .zero       (zero)
    );

    assign bus.load_ready = ready;
    assign bus.sout       = sout_c;
    assign bus.sout_valid = valid_c;
    assign bus.done       = done_q;
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port load_valid, input, 1 bit, meaning a parallel word is offered on din.
REQ-005 The block SHALL have port din, input, WIDTH bits, the parallel word to serialize.
REQ-006 The block SHALL have port load_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have port sout, output, 1 bit, the serial data bit.
REQ-008 The block SHALL have port sout_valid, output, 1 bit, meaning sout carries a meaningful bit this cycle.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit of a frame.

Function
REQ-010 A load SHALL occur on a clock edge where load_valid=1 and load_ready=1; din SHALL be captured into an internal shift register.
REQ-011 The state machine SHALL have states IDLE, SHIFT and, with the parity feature only, PARITY.
REQ-012 In IDLE, load_ready SHALL be 1, sout_valid SHALL be 0 and sout SHALL be 0.
REQ-013 A load in IDLE SHALL move the block to SHIFT and set the bit counter to WIDTH-1.
REQ-014 In SHIFT, sout SHALL be the MSB of the shift register, sout_valid SHALL be 1, and each clock SHALL shift left by one with zero fill and decrement the counter.
REQ-015 The first data bit SHALL appear on sout in the cycle after the load edge, which is a latency of 1 cycle.
REQ-016 A frame SHALL emit exactly WIDTH data bits on consecutive cycles, MSB first, with no gaps.
REQ-017 When the counter reaches 0 in SHIFT, the next state SHALL be PARITY if the parity feature is enabled, otherwise IDLE.
REQ-018 done SHALL pulse high for exactly one cycle, in the cycle after the final bit of the frame (data or parity).
REQ-019 load_ready SHALL also be 1 during the final bit cycle of a frame, so that a load on that edge starts the next frame back-to-back; done SHALL still pulse and sout_valid SHALL stay 1 with no gap.
REQ-020 In all other SHIFT and PARITY cycles, load_ready SHALL be 0, and load_valid SHALL be ignored there without corrupting the frame.
REQ-021 din SHALL be sampled only on the load edge; later changes to din SHALL NOT affect the frame in progress.

Reset
REQ-022 When rst_n is low, the block SHALL immediately enter IDLE and clear the shift register, counter, sout, sout_valid and done to 0.
REQ-023 Asserting reset mid-frame SHALL abort the frame, with no done pulse, and the remaining bits SHALL be discarded.
REQ-024 After reset is released, load_ready SHALL be 1 from the first clock edge.

Configuration
REQ-025 When macro PISO_PARITY_EN is defined, the block SHALL emit one even-parity bit (XOR of the captured word) in state PARITY after the data bits, with sout_valid=1, giving a frame of WIDTH+1 bits.
REQ-026 When PISO_PARITY_EN is undefined, the PARITY state and the parity register SHALL be absent, and the frame SHALL be WIDTH bits.

Structure
REQ-027 Package piso_pkg SHALL hold the state enumeration type (IDLE/SHIFT/PARITY) and the default WIDTH constant.
REQ-028 The counter SHALL be sized $clog2(WIDTH) bits, and its width SHALL be derived in the package via a function.
REQ-029 The block SHALL instantiate one sub-module, piso_bit_counter, a loadable down-counter with a zero flag; everything else SHALL be in piso_serializer.

Verification
REQ-030 The bench SHALL cover: reset, then load din=8'hA5 with parity disabled -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then done=1 for one cycle, then load_ready=1.
REQ-031 The bench SHALL cover: with PISO_PARITY_EN defined, load 8'h07 -> 00000111 then parity bit 1, giving 9 valid cycles, then done.
REQ-032 The bench SHALL cover: load 8'hFF and hold load_valid=1 with din=8'h00 -> a second load on the last-bit edge, 16 contiguous valid bits, and two done pulses 8 cycles apart.
REQ-033 The bench SHALL cover: toggle din and load_valid during the frame of 8'h3C -> the output stream is unchanged (00111100) and no extra load occurs.
REQ-034 The bench SHALL cover: drop rst_n after the 4th bit of 8'hC3 -> outputs are 0 immediately, there is no done pulse, and a fresh load of 8'h81 serializes correctly.
REQ-035 The bench SHALL cover: WIDTH=2, load 2'b10 -> sout=1,0 then done, confirming counter sizing at the minimum width.
